serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial WIDTH-bit subtractor computing A − B, one bit per clock, LSB first, with a single borrow flip-flop. It is the inverse-direction companion to the team's combinational half adder (sum/carry) and targets the same small-area TinyTapeout tiles. A start/busy/done handshake wraps it so a tile top can drive operands from `ui_in`/`uio_in` and present the difference on `uo_out`.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..16.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend; captured on the accepting edge only.
- `b`  in  WIDTH  subtrahend; captured on the accepting edge only.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `diff`  out  WIDTH  result (A − B) mod 2^WIDTH; held until the next accept.
- `borrow_out`  out  1  final borrow: 1 iff A < B, unsigned; held with `diff`.
- `diff_bit`  out  1  current serial difference bit; valid when `busy`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE after WIDTH bit-cycles.
  - DONE → RUN on `start`; otherwise DONE → IDLE.
- Accept edge:
  - Load `a` into the shift register SA and `b` into SB.
  - Clear the borrow flop BR and the bit counter CNT.
  - Clear the internal result shift register SD.
- Each RUN cycle, with bit-cycle index k = CNT:
  - d = SA[0] ^ SB[0] ^ BR.
  - br' = (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & BR).
  - SA and SB shift right one place.
  - d shifts into SD at the MSB.
  - BR ← br'. CNT increments.
- `diff_bit` = d combinationally during RUN; 0 otherwise.
- On the last RUN edge (CNT = WIDTH−1), copy the SD contents including the final d into `diff`, and copy br' into `borrow_out`.
- `start` while `busy` is ignored: no restart, operands are not re-sampled.
- `a` and `b` may change freely after the accept edge without affecting the result.
- CNT width is $clog2(WIDTH)+1. No wrap-around occurs, because CNT is cleared on every accept.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `diff_bit`=0.
  - SA, SB, SD, BR and CNT all 0.
- `start` high in cycle 0 (accepted at the end of cycle 0):
  - `busy` high in cycles 1..WIDTH.
  - `done` high in cycle WIDTH+1 only.
  - `diff` and `borrow_out` are valid from cycle WIDTH+1.
- Start-to-done latency is WIDTH+1 cycles. Maximum throughput is one result per WIDTH+1 cycles, because `start` held high continuously re-accepts in DONE.
- If `start` is accepted in DONE, `done` is still high for that cycle and `busy` rises in the next cycle.
- Reset asserted mid-RUN:
  - All state clears immediately and asynchronously.
  - No `done` pulse is produced and the previous `diff` is lost (reads 0).
  - After reset deasserts, the first `start` behaves as the first one after power-up.
- All outputs are registered except `diff_bit`, which is combinational from registered state.

## Structure
- Package `serial_subtractor_pkg`:
  - State enum `sub_state_t` with values IDLE, RUN, DONE.
  - Constant `SUB_WIDTH_DEFAULT = 8`.
- Sub-module `full_subtractor_bit`, purely combinational:
  - Inputs `x`, `y`, `bin`.
  - Outputs `d`, `bout`.
  - Instantiated once for the serial datapath.
- Top level holds the FSM, counter, shift registers and output registers.

## Test plan
- Reset, then `start` with a=0x05, b=0x03 → `done` in cycle 9, `diff`=0x02, `borrow_out`=0; `diff_bit` sequence 0,1,0,0,0,0,0,0 (LSB first).
- a=0x03, b=0x05 → `diff`=0xFE, `borrow_out`=1; `busy` high for exactly 8 cycles.
- Edge operands: a=0x00, b=0x00 → 0x00, borrow 0. a=0x00, b=0xFF → 0x01, borrow 1. a=0xFF, b=0xFF → 0x00, borrow 0.
- `start` pulsed in cycles 3 and 5 of a run with a=0x80, b=0x01 → ignored; a single `done` gives 0x7F, borrow 0. Changing `a` and `b` after acceptance has no effect.
- `start` held high continuously with a=0x10, b=0x20 → `done` in cycles 9, 18, 27…, each with 0xF0 and borrow 1; `busy` is low only in the `done` cycles.
- `rst` asserted in cycle 4 of a run → `busy`, `done`, `diff` and `borrow_out` read 0 in the same cycle. A fresh run with a=0x09, b=0x04 → 0x05.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one borrow flop, wrapped in a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start, last result held
// RUN   | shifting one operand bit per clock
// DONE  | result valid for one cycle; start here re-accepts immediately
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             diff_bit
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d_next;
    logic             br_next;

    full_subtractor_bit u_bit (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (br),
        .d    (d_next),
        .bout (br_next)
    );

    assign diff_bit = (state == RUN) ? d_next : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            sd         <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == RUN) begin
                // start is deliberately not looked at here: operands stay frozen
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                sd  <= {d_next, sd[WIDTH-1:1]};
                br  <= br_next;
                cnt <= cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    state      <= DONE;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    diff       <= {d_next, sd[WIDTH-1:1]};
                    borrow_out <= br_next;
                end
            end else if (start) begin
                state <= RUN;
                busy  <= 1'b1;
                sa    <= a;
                sb    <= b;
                sd    <= '0;
                br    <= 1'b0;
                cnt   <= '0;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         diff_bit;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .diff_bit   (diff_bit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   32'(busy),       32'd0);
        check({tag, "_done"},   32'(done),       32'd0);
        check({tag, "_diff"},   32'(diff),       32'd0);
        check({tag, "_borrow"}, 32'(borrow_out), 32'd0);
        check({tag, "_dbit"},   32'(diff_bit),   32'd0);
    endtask

    // Accept in cycle 0, scramble operands after accept, then check the whole run.
    task automatic do_run(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb);
        logic [W-1:0] bits;
        int busy_cnt;
        int done_cnt;
        bits = '0;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            bits[k] = diff_bit;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        @(negedge clk);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, "_early_done"},  32'(done_cnt), 32'd0);
        check({tag, "_done"},        32'(done),     32'd1);
        check({tag, "_busy_end"},    32'(busy),     32'd0);
        check({tag, "_diff"},        32'(diff),     32'(ed));
        check({tag, "_borrow"},      32'(borrow_out), 32'(eb));
        check({tag, "_bits"},        32'(bits),     32'(ed));
        @(negedge clk);
        check({tag, "_done_pulse"},  32'(done),     32'd0);
        check({tag, "_diff_hold"},   32'(diff),     32'(ed));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        do_run("r05_03", 8'h05, 8'h03, 8'h02, 1'b0);
        do_run("r03_05", 8'h03, 8'h05, 8'hFE, 1'b1);
        do_run("r00_00", 8'h00, 8'h00, 8'h00, 1'b0);
        do_run("r00_ff", 8'h00, 8'hFF, 8'h01, 1'b1);
        do_run("rff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0);

        // start pulses in cycles 3 and 5 must be ignored
        begin
            int done_cnt;
            int busy_cnt;
            done_cnt = 0;
            busy_cnt = 0;
            @(negedge clk);
            a = 8'h80;
            b = 8'h01;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            a = 8'hFF;
            b = 8'hFF;
            for (int k = 1; k <= W; k++) begin
                @(negedge clk);
                if (done) done_cnt++;
                if (busy) busy_cnt++;
                start = (k == 3 || k == 5);
            end
            @(negedge clk);
            check("ign_early_done", 32'(done_cnt), 32'd0);
            check("ign_busy_cycles", 32'(busy_cnt), 32'd8);
            check("ign_done", 32'(done), 32'd1);
            check("ign_diff", 32'(diff), 32'h7F);
            check("ign_borrow", 32'(borrow_out), 32'd0);
            @(negedge clk);
            check("ign_done_pulse", 32'(done), 32'd0);
            check("ign_no_restart", 32'(busy), 32'd0);
        end

        // start held high: back-to-back results every 9 cycles
        @(negedge clk);
        a = 8'h10;
        b = 8'h20;
        start = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            check($sformatf("cont_done_c%0d", c), 32'(done), 32'((c % 9) == 0));
            check($sformatf("cont_busy_c%0d", c), 32'(busy), 32'((c % 9) != 0));
            if ((c % 9) == 0) begin
                check($sformatf("cont_diff_c%0d", c), 32'(diff), 32'hF0);
                check($sformatf("cont_borrow_c%0d", c), 32'(borrow_out), 32'd1);
            end
            if (c == 27) start = 1'b0;
        end
        @(negedge clk);
        check("cont_stop_busy", 32'(busy), 32'd0);
        check("cont_stop_diff", 32'(diff), 32'hF0);

        // reset asserted in cycle 4 of a run
        @(negedge clk);
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2) @(negedge clk);
        check("mid_no_done", 32'(done), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);

        do_run("r09_04", 8'h09, 8'h04, 8'h05, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
